gpio_responder: RTL and testbench
=================================

# gpio_responder

Bus-side responder for the board's switch/LED I/O. It sits inside the mother board between the CPU data bus and the raw `switch`/`led` lines of the I/O bus. It synchronises and debounces the switch inputs, latches change events, and holds the LED output register. The CPU reads and writes four word registers through a single-request/single-acknowledge handshake.

## Interface

Parameters:
- WIDTH, 4, number of switch inputs and LED outputs; register data width.
- DEBOUNCE, 4, consecutive cycles a synchronised switch level must differ from the stable level before it is accepted; legal range ≥ 1.

Ports:
- clk  in  1  single clock for all state.
- n_reset  in  1  asynchronous, active-low reset.
- req  in  1  bus request; held high by the initiator until `ack`.
- we  in  1  1 = write, 0 = read; valid while `req`=1.
- addr  in  2  register select.
- wdata  in  WIDTH  write data; valid while `req`=1 and `we`=1.
- rdata  out  WIDTH  read data; valid only while `ack`=1, otherwise 0.
- ack  out  1  one-cycle completion pulse.
- switch  in  WIDTH  raw asynchronous switch levels.
- led  out  WIDTH  LED drive; equals the LED register.

## Operation

- Register map:
  - addr 0 SW: read returns debounced switch levels. Writes are ignored but still acknowledged.
  - addr 1 LED: read/write.
  - addr 2 CHG: per-bit sticky change flags. Read returns the flags. A write clears the bits where `wdata` is 1 (write-1-to-clear).
  - addr 3 TGL: a write XORs `wdata` into LED. A read returns LED.
- Input path, per bit:
  - Two-flop synchroniser `sync1` → `sync2`.
  - Debounce counter `cnt`, width $clog2(DEBOUNCE+1).
  - On each edge:
    - If `sync2` ≠ `stable` and `cnt` = DEBOUNCE−1: `stable` ← `sync2`, `cnt` ← 0, and set the CHG bit.
    - Else if `sync2` ≠ `stable`: `cnt` ← `cnt`+1.
    - Else: `cnt` ← 0. Any glitch shorter than DEBOUNCE cycles restarts the count.
- Handshake FSM, two states:
  - IDLE: when `req`=1, sample `we`/`addr`/`wdata` and perform the write or read. Drive `ack`=1 and register `rdata` at the same edge, then go to ACK.
  - ACK: `ack`=1 for exactly this cycle. `req` is ignored. Return to IDLE at the next edge, with `ack`=0 and `rdata`=0.
  - Maximum throughput is one transaction per 2 cycles. The initiator drops `req` in the cycle it sees `ack`. A `req` still high in IDLE after ACK starts a new transaction.
- Simultaneous events:
  - A CHG bit being set by the debouncer and cleared by a W1C write in the same edge ends up set.
  - A CHG read in the same edge as a set returns the pre-edge value.
  - A write to LED/TGL takes effect on `led` from the edge that raises `ack`.

## Timing

- Reset (asynchronous, `n_reset`=0) forces:
  - `ack`=0, `rdata`=0, `led`=0.
  - LED, CHG, `stable`, `sync1`, `sync2` and `cnt` all 0.
  - FSM to IDLE.
- Reset mid-transaction aborts it with no `ack`. The initiator must reissue.
- Because `stable` resets to 0, a switch held at 1 through reset raises its CHG bit 2+DEBOUNCE cycles after release.
- Switch-to-SW latency: a level applied before edge k is in `sync2` after edge k+1. It is accepted into `stable` and CHG at edge k+1+DEBOUNCE, i.e. edge k+5 at the default.
- Request-to-ack latency: `req` high before edge n gives `ack`/`rdata` valid after edge n, for one cycle.
- Read data reflects register contents before edge n.

## Test plan

- Reset: assert `n_reset`=0 mid-ACK with `led` previously 4'hA → `ack`, `rdata` and `led` drop to 0 immediately (asynchronous); SW and CHG read 0 after release.
- LED write/toggle:
  - Write addr1=4'h5 → `led`=4'h5 on the `ack` edge.
  - Write addr3=4'hF → `led`=4'hA.
  - Read addr1 → `rdata`=4'hA with `ack`.
- Debounce:
  - Switch 4'h0→4'h3 before edge 0 → SW reads 4'h3 from edge 5 and CHG=4'h3.
  - A 3-cycle pulse on bit 2 → SW and CHG bit 2 unchanged.
- W1C collision: CHG=4'h1, write addr2=4'h3 at the same edge that bit 1 is debounced → CHG=4'h2 afterwards.
- Handshake:
  - `req` held high for 5 cycles with reads of addr0 → `ack` pulses on alternate cycles (3 pulses), `rdata`=0 between pulses.
  - Write to addr0 → acknowledged, SW unaffected.

Source files
------------

// File: rtl/gpio_responder.sv
// Bus-side responder for the switch/LED I/O lines: synchronises and debounces
// the switches, latches sticky change flags and holds the LED register.
module gpio_responder #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] led
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [1:0] ADDR_SW  = 2'd0;
    localparam logic [1:0] ADDR_LED = 2'd1;
    localparam logic [1:0] ADDR_CHG = 2'd2;
    localparam logic [1:0] ADDR_TGL = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic                       ack_q, ack_d;
    logic [WIDTH-1:0]           rdata_q, rdata_d;
    logic [WIDTH-1:0]           led_q, led_d;
    logic [WIDTH-1:0]           chg_q, chg_d;
    logic [WIDTH-1:0]           sync1_q, sync1_d;
    logic [WIDTH-1:0]           sync2_q, sync2_d;
    logic [WIDTH-1:0]           stable_q, stable_d;
    logic [WIDTH-1:0][CW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]           chg_set;
    logic [WIDTH-1:0]           chg_clr;
    logic [WIDTH-1:0]           rd_mux;

    always_comb begin
        sync1_d = switch;
        sync2_d = sync1_q;
    end

    // Each bit must disagree with the stable level for DEBOUNCE edges in a row.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        chg_set  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                    chg_set[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_SW:  rd_mux = stable_q;
            ADDR_LED: rd_mux = led_q;
            ADDR_CHG: rd_mux = chg_q;
            ADDR_TGL: rd_mux = led_q;
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        led_d   = led_q;
        chg_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                    if (we) begin
                        case (addr)
                            ADDR_LED: led_d   = wdata;
                            ADDR_CHG: chg_clr = wdata;
                            ADDR_TGL: led_d   = led_q ^ wdata;
                            default:  led_d   = led_q;
                        endcase
                    end else begin
                        rdata_d = rd_mux;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A debouncer set wins over a same-edge write-1-to-clear.
    always_comb begin
        chg_d = (chg_q & ~chg_clr) | chg_set;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            led_q    <= '0;
            chg_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            chg_q    <= chg_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign led   = led_q;

endmodule

// File: tb/tb_gpio_responder.sv
// Directed bench for gpio_responder: register access, debounce timing,
// W1C collision, back-to-back handshake and asynchronous reset.
module tb_gpio_responder;

    localparam int WIDTH    = 4;
    localparam int DEBOUNCE = 4;

    logic             clk;
    logic             n_reset;
    logic             req;
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] led;

    int n_checks = 0;
    int n_errors = 0;

    gpio_responder #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .switch  (switch),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: req raised at a falling edge, ack sampled after the next rising edge.
    task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [WIDTH-1:0] d,
                            output logic [WIDTH-1:0] rd);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        check("xfer_ack", 32'(ack), 32'd1);
        rd = rdata;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    logic [WIDTH-1:0] rd;

    initial begin
        n_reset = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        wdata   = '0;
        switch  = '0;

        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // LED write, toggle and read-back
        bus_xfer(1'b1, 2'd1, 4'h5, rd);
        check("led_write", 32'(led), 32'h5);
        bus_xfer(1'b1, 2'd3, 4'hF, rd);
        check("led_toggle", 32'(led), 32'hA);
        bus_xfer(1'b0, 2'd1, 4'h0, rd);
        check("rd_led", 32'(rd), 32'hA);
        bus_xfer(1'b0, 2'd3, 4'h0, rd);
        check("rd_tgl", 32'(rd), 32'hA);
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("rd_sw_init", 32'(rd), 32'h0);

        // Debounce: switch changes before edge 0, accepted at edge 5
        switch = 4'h3;
        repeat (5) @(posedge clk);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("chg_pre_edge5", 32'(rd), 32'h0);
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("sw_accepted", 32'(rd), 32'h3);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("chg_set", 32'(rd), 32'h3);
        bus_xfer(1'b1, 2'd2, 4'h3, rd);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("chg_w1c", 32'(rd), 32'h0);

        // Three-cycle glitch on bit 2 is rejected
        switch = 4'h7;
        repeat (3) @(negedge clk);
        switch = 4'h3;
        repeat (10) @(negedge clk);
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("glitch_sw", 32'(rd), 32'h3);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("glitch_chg", 32'(rd), 32'h0);

        // req held for five cycles: ack on alternate cycles
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hs_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("hs_rdata", 32'(rdata), (i % 2 == 0) ? 32'h3 : 32'h0);
        end
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);

        // Write to SW is acknowledged but ignored
        bus_xfer(1'b1, 2'd0, 4'hF, rd);
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("sw_wr_ignored", 32'(rd), 32'h3);
        check("sw_wr_led", 32'(led), 32'hA);

        // Bit 0 falls, giving CHG = 1
        switch = 4'h2;
        repeat (10) @(negedge clk);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("chg_bit0", 32'(rd), 32'h1);

        // Bit 1 falls and is accepted at the same edge as a W1C of 4'h3
        switch = 4'h0;
        repeat (5) @(posedge clk);
        bus_xfer(1'b1, 2'd2, 4'h3, rd);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("w1c_collision", 32'(rd), 32'h2);
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("sw_zero", 32'(rd), 32'h0);

        // Asynchronous reset in the middle of the ACK cycle
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 2'd1;
        @(posedge clk);
        #1;
        check("pre_rst_ack", 32'(ack), 32'd1);
        check("pre_rst_rdata", 32'(rdata), 32'hA);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_ack", 32'(ack), 32'd0);
        check("async_rdata", 32'(rdata), 32'h0);
        check("async_led", 32'(led), 32'h0);
        @(negedge clk);
        req     = 1'b0;
        n_reset = 1'b1;
        bus_xfer(1'b0, 2'd0, 4'h0, rd);
        check("post_rst_sw", 32'(rd), 32'h0);
        bus_xfer(1'b0, 2'd2, 4'h0, rd);
        check("post_rst_chg", 32'(rd), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
